// File: rtl/led_pwm_pkg.sv
// Shared constants and helpers for the LED PWM fader.
// Fade behaviour is selected by LED_PWM_FADE_EN in the files that import this package.
package led_pwm_pkg;

    localparam int LED_PWM_BITS_DEF = 8;
    localparam int LED_COUNT_DEF    = 10;
    localparam int LED_PRESCALE_DEF = 196;
    localparam int LED_FADE_DIV_DEF = 4;

    function automatic int pwm_max(input int bits);
        return (1 << bits) - 1;
    endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: intensity register, frame-latched compare level and registered PWM output.
// With LED_PWM_FADE_EN defined the intensity ramps down one step per fade_step; otherwise it drops to 0.
module led_pwm_channel
    import led_pwm_pkg::*;
#(
    parameter int PWM_BITS = LED_PWM_BITS_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                led_q,
    input  logic                wrap,
`ifdef LED_PWM_FADE_EN
    input  logic                fade_step,
`endif
    input  logic [PWM_BITS-1:0] pwm_cnt,
    input  logic [PWM_BITS-1:0] brightness,
    output logic                led_out
);

    localparam logic [PWM_BITS-1:0] MAX = PWM_BITS'(pwm_max(PWM_BITS));

    logic [PWM_BITS-1:0] intensity_reg;
    logic [PWM_BITS-1:0] intensity_next;
    logic [PWM_BITS-1:0] cmp_reg;
    logic [PWM_BITS-1:0] cmp_next;

    always_comb begin
        intensity_next = intensity_reg;
        if (led_q) begin
            intensity_next = MAX;
`ifdef LED_PWM_FADE_EN
        end else if (fade_step && (intensity_reg != '0)) begin
            intensity_next = intensity_reg - 1'b1;
`else
        end else begin
            intensity_next = '0;
`endif
        end
    end

    // Capping happens at latch time, so the whole frame uses one consistent level.
    assign cmp_next = (intensity_reg < brightness) ? intensity_reg : brightness;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            intensity_reg <= '0;
            cmp_reg       <= '0;
            led_out       <= 1'b0;
        end else begin
            intensity_reg <= intensity_next;
            if (wrap) begin
                cmp_reg <= cmp_next;
            end
            // Full scale is forced on so the top level has no one-step notch.
            led_out <= (cmp_reg == MAX) ? 1'b1 : (pwm_cnt < cmp_reg);
        end
    end

endmodule

// File: rtl/led_pwm_fader.sv
// LED PWM fader: shared prescaler, PWM frame counter and fade divider feeding NUM_LEDS channels.
// Define LED_PWM_FADE_EN for a linear afterglow; without it an LED turns off at the next frame.
module led_pwm_fader
    import led_pwm_pkg::*;
#(
    parameter int NUM_LEDS = LED_COUNT_DEF,
    parameter int PWM_BITS = LED_PWM_BITS_DEF,
    parameter int PRESCALE = LED_PRESCALE_DEF,
    parameter int FADE_DIV = LED_FADE_DIV_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_LEDS-1:0] led_in,
    input  logic [PWM_BITS-1:0] brightness,
    output logic [NUM_LEDS-1:0] led_out,
    output logic                frame_start
);

    localparam logic [PWM_BITS-1:0] MAX = PWM_BITS'(pwm_max(PWM_BITS));
    localparam int                  PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0]     PS_LAST = PS_W'(PRESCALE - 1);

    if ((PRESCALE < 1) || (FADE_DIV < 1)) begin : g_bad_cfg
        $error("led_pwm_fader: PRESCALE and FADE_DIV must both be at least 1");
    end

    logic [PS_W-1:0]     presc_reg;
    logic [PWM_BITS-1:0] pwm_cnt_reg;
    logic [NUM_LEDS-1:0] led_q_reg;
    logic                tick;
    logic                wrap;

    assign tick = (presc_reg == PS_LAST);
    assign wrap = tick && (pwm_cnt_reg == MAX);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_reg   <= '0;
            pwm_cnt_reg <= '0;
            led_q_reg   <= '0;
            frame_start <= 1'b0;
        end else begin
            led_q_reg   <= led_in;
            frame_start <= wrap;
            presc_reg   <= tick ? '0 : presc_reg + 1'b1;
            if (tick) begin
                pwm_cnt_reg <= pwm_cnt_reg + 1'b1;
            end
        end
    end

`ifdef LED_PWM_FADE_EN
    localparam int              FD_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam logic [FD_W-1:0] FD_LAST = FD_W'(FADE_DIV - 1);

    logic [FD_W-1:0] fade_cnt_reg;
    logic            fade_step;

    assign fade_step = wrap && (fade_cnt_reg == FD_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fade_cnt_reg <= '0;
        end else if (wrap) begin
            fade_cnt_reg <= fade_step ? '0 : fade_cnt_reg + 1'b1;
        end
    end
`endif

    for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_chan
        led_pwm_channel #(
            .PWM_BITS (PWM_BITS)
        ) u_chan (
            .clk        (clk),
            .reset_n    (reset_n),
            .led_q      (led_q_reg[gi]),
            .wrap       (wrap),
`ifdef LED_PWM_FADE_EN
            .fade_step  (fade_step),
`endif
            .pwm_cnt    (pwm_cnt_reg),
            .brightness (brightness),
            .led_out    (led_out[gi])
        );
    end

endmodule

// File: tb/tb_led_pwm_fader.sv
// Randomized bench for led_pwm_fader against a frame-arithmetic reference model.
// Honours LED_PWM_FADE_EN the same way the design does.
module tb_led_pwm_fader;

    localparam int N     = 10;
    localparam int PB    = 4;
    localparam int PS    = 1;
    localparam int FD    = 1;
    localparam int MAXV  = 15;
    localparam int FRAME = (MAXV + 1) * PS;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [N-1:0]  led_in = '0;
    logic [PB-1:0] brightness = '0;
    logic [N-1:0]  led_out;
    logic          frame_start;

    int total = 0;
    int bad   = 0;

    led_pwm_fader #(
        .NUM_LEDS (N),
        .PWM_BITS (PB),
        .PRESCALE (PS),
        .FADE_DIV (FD)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .led_in      (led_in),
        .brightness  (brightness),
        .led_out     (led_out),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: frame position comes from the edge count since reset,
    // intensity follows the on / fade / off rules, cmp is latched at frame ends.
    int           k = 0;
    int           m_int [N];
    int           m_cmp [N];
    logic [N-1:0] m_q = '0;
    logic [N-1:0] exp_out = '0;
    logic         exp_fs = 1'b0;
    int           pos;
    int           wraps;
    bit           wr;
    bit           fstep;

    initial begin
        for (int i = 0; i < N; i++) begin
            m_int[i] = 0;
            m_cmp[i] = 0;
        end
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            k = 0;
            m_q = '0;
            exp_out = '0;
            exp_fs = 1'b0;
            for (int i = 0; i < N; i++) begin
                m_int[i] = 0;
                m_cmp[i] = 0;
            end
        end else begin
            k++;
            pos   = ((k - 1) / PS) % (MAXV + 1);
            wr    = (k % FRAME) == 0;
            wraps = k / FRAME;
            fstep = wr && (((wraps - 1) % FD) == FD - 1);
            for (int i = 0; i < N; i++) begin
                exp_out[i] = (m_cmp[i] == MAXV) ? 1'b1 : (pos < m_cmp[i]);
            end
            exp_fs = wr;
            if (wr) begin
                for (int i = 0; i < N; i++) begin
                    m_cmp[i] = (m_int[i] < int'(brightness)) ? m_int[i] : int'(brightness);
                end
            end
            for (int i = 0; i < N; i++) begin
                if (m_q[i]) begin
                    m_int[i] = MAXV;
`ifdef LED_PWM_FADE_EN
                end else if (fstep && m_int[i] > 0) begin
                    m_int[i] = m_int[i] - 1;
`else
                end else begin
                    m_int[i] = 0;
`endif
                end
            end
            m_q = led_in;
        end
    end

    task automatic step(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            check("led_out", led_out, exp_out);
            check("frame_start", frame_start, exp_fs);
        end
    endtask

    task automatic drive(input logic [N-1:0] l, input logic [PB-1:0] b, input int n);
        led_in     = l;
        brightness = b;
        step(n);
    endtask

    task automatic pulse_reset(input int n);
        reset_n = 1'b0;
        step(n);
        check("reset_out", led_out, 32'h0);
        check("reset_fs", frame_start, 32'h0);
        reset_n = 1'b1;
    endtask

    logic [PB-1:0] rb;

    initial begin
        step(3);
        check("reset_out", led_out, 32'h0);
        check("reset_fs", frame_start, 32'h0);
        reset_n = 1'b1;

        // idle, then reset in the middle of a frame
        drive('0, PB'(9), 2 * FRAME + 5);
        pulse_reset(2);
        drive('0, PB'(9), 3 * FRAME);

        // duty, full-scale, and mid-frame brightness change
        drive(10'h001, PB'(6), 3 * FRAME);
        drive(10'h001, PB'(15), 2 * FRAME);
        drive(10'h001, PB'(6), FRAME + 3);
        drive(10'h001, PB'(2), 3 * FRAME);
        drive(10'h001, PB'(0), 2 * FRAME);

        // fade-out of LED 3, then a fade interrupted part-way
        drive(10'h008, PB'(15), 2 * FRAME);
        drive(10'h000, PB'(15), FRAME * FD * (MAXV + 2) + 20);
        drive(10'h008, PB'(15), 2 * FRAME);
        drive(10'h000, PB'(15), FRAME * FD * 10 + 7);
        drive(10'h008, PB'(15), 3 * FRAME);

        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 3))
                0:       rb = '0;
                1:       rb = PB'(MAXV);
                default: rb = PB'($urandom);
            endcase
            drive(N'($urandom), rb, $urandom_range(1, 40));
            if (it == 30) pulse_reset($urandom_range(1, 4));
        end

        drive('0, PB'(15), FRAME * FD * (MAXV + 2) + 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
